// File: rtl/spi_slave_tx_fifo_if.sv
// Bus between the slave protocol controller / SPI pads and spi_slave_tx_fifo.
// The slave modport is the transmit engine's view; master is the driver side.
`timescale 1ns/1ps
interface spi_slave_tx_fifo_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic              sclk;
  logic              cs;
  logic [1:0]        mode;
  logic [CNT_W-1:0]  counter_in;
  logic              counter_in_upd;
  logic [DATA_W-1:0] data;
  logic              data_valid;
  logic              data_ready;
  logic [3:0]        sdo;
  logic [3:0]        oe;
  logic              done;
  logic              underrun;

  modport slave (
    input  sclk, cs, mode, counter_in, counter_in_upd, data, data_valid,
    output data_ready, sdo, oe, done, underrun
  );

  modport master (
    output sclk, cs, mode, counter_in, counter_in_upd, data, data_valid,
    input  data_ready, sdo, oe, done, underrun
  );
endinterface

// File: rtl/spi_slave_tx_fifo.sv
// SPI slave transmit engine with word FIFO, clocked entirely on sys_clk.
// Define SPI_TX_MULTILANE_EN to honour mode (dual/quad lanes); otherwise single lane only.
//
// state    | meaning
// ST_IDLE  | cs inactive, waiting for cs_s low
// ST_ARMED | selected, waiting for counter_in_upd to load first word
// ST_SHIFT | shifting words out on falling sclk_s
`timescale 1ns/1ps
module spi_slave_tx_fifo #(
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               sys_clk,
  input  logic               rstn,
  spi_slave_tx_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int BP_W  = $clog2(DATA_W) + 1;
  localparam logic [BP_W-1:0]  WORD_BITS = BP_W'(DATA_W);
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_SHIFT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic [CNT_W-1:0]       counter_q, counter_d;
  logic [CNT_W-1:0]       target_q, target_d;
  logic [BP_W-1:0]        bitpos_q, bitpos_d;
  logic [DATA_W-1:0]      shreg_q, shreg_d;
  logic [DATA_W-1:0]      mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]         count_q, count_d;
  logic                   done_q, done_d;
  logic                   underrun_q, underrun_d;

  logic              cs_s, sclk_s, shift_ev, cs_rise;
  logic              full, empty, push, pop, pop_ok, last_ev;
  logic [2:0]        lanes;
  logic [3:0]        lane_mask, sdo_w;
  logic [DATA_W-1:0] shifted, pop_word;
  logic [BP_W-1:0]   next_bitpos;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
  end

  assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign shift_ev = sclk_prev_q & ~sclk_s & ~cs_s;
  assign cs_rise  = ~cs_prev_q & cs_s;

`ifdef SPI_TX_MULTILANE_EN
  always_comb begin
    case (bus.mode)
      2'b01: begin
        lanes     = 3'd2;
        lane_mask = 4'h3;
        shifted   = {shreg_q[DATA_W-3:0], 2'b00};
        sdo_w     = {2'b00, shreg_q[DATA_W-1 -: 2]};
      end
      2'b10: begin
        lanes     = 3'd4;
        lane_mask = 4'hF;
        shifted   = {shreg_q[DATA_W-5:0], 4'h0};
        sdo_w     = shreg_q[DATA_W-1 -: 4];
      end
      default: begin
        lanes     = 3'd1;
        lane_mask = 4'h1;
        shifted   = {shreg_q[DATA_W-2:0], 1'b0};
        sdo_w     = {3'b000, shreg_q[DATA_W-1]};
      end
    endcase
  end
`else
  logic [1:0] unused_mode;
  assign unused_mode = bus.mode;
  assign lanes       = 3'd1;
  assign lane_mask   = 4'h1;
  assign shifted     = {shreg_q[DATA_W-2:0], 1'b0};
  assign sdo_w       = {3'b000, shreg_q[DATA_W-1]};
`endif

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign push     = bus.data_valid & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_word = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    target_d    = target_q;
    bitpos_d    = bitpos_q;
    shreg_d     = shreg_q;
    done_d      = 1'b0;
    underrun_d  = underrun_q;
    pop         = 1'b0;
    // Completion compare is one bit wider so counter+L cannot wrap.
    last_ev     = ({1'b0, counter_q} + {{(CNT_W-2){1'b0}}, lanes}) > {1'b0, target_q};
    next_bitpos = bitpos_q + {{(BP_W-3){1'b0}}, lanes};

    case (state_q)
      ST_IDLE: begin
        if (!cs_s) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (bus.counter_in_upd) begin
          target_d = bus.counter_in;
          pop      = 1'b1;
          shreg_d  = pop_word;
          bitpos_d = '0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.counter_in_upd) target_d = bus.counter_in;
        if (shift_ev) begin
          if (last_ev) begin
            done_d    = 1'b1;
            counter_d = '0;
            state_d   = ST_ARMED;
          end else begin
            counter_d = counter_q + {{(CNT_W-3){1'b0}}, lanes};
            if (next_bitpos == WORD_BITS) begin
              pop      = 1'b1;
              shreg_d  = pop_word;
              bitpos_d = '0;
            end else begin
              shreg_d  = shifted;
              bitpos_d = next_bitpos;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop && empty) underrun_d = 1'b1;

    if (cs_rise) begin
      state_d    = ST_IDLE;
      counter_d  = '0;
      target_d   = CNT_W'(7);
      bitpos_d   = '0;
      shreg_d    = '0;
      done_d     = 1'b0;
      underrun_d = 1'b0;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (cs_rise) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      counter_q   <= '0;
      target_q    <= CNT_W'(7);
      bitpos_q    <= '0;
      shreg_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      counter_q   <= counter_d;
      target_q    <= target_d;
      bitpos_q    <= bitpos_d;
      shreg_q     <= shreg_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
      mem_q       <= mem_d;
    end
  end

  assign bus.sdo        = sdo_w;
  assign bus.oe         = (state_q == ST_SHIFT) ? lane_mask : 4'h0;
  assign bus.done       = done_q;
  assign bus.underrun   = underrun_q;
  assign bus.data_ready = ~full;
endmodule
